// File: rtl/rv_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// rv_hazard_ctrl_if
// Bundles every hazard-control signal exchanged between the 5-stage RV32I
// pipeline datapath and the hazard sequencer (rv_hazard_ctrl).
//
// Modports
//   master : pipeline datapath side; drives the i_haz_* fields and consumes
//            the o_haz_* stall/flush/forward controls.
//   slave  : hazard sequencer side; consumes i_haz_* and drives o_haz_*.
//
// Fields (direction seen from the slave)
//   i_haz_id_ra1/ra2        in   5   ID-stage source register addresses
//   i_haz_ex_ra1/ra2        in   5   EX-stage source register addresses
//   i_haz_ex_rf_wa/we       in   5/1 EX-stage destination and write enable
//   i_haz_ex_is_load        in   1   EX instruction is a load
//   i_haz_ex_redirect       in   1   EX branch taken or jump
//   i_haz_mem_rf_wa/we      in   5/1 MEM-stage destination and write enable
//   i_haz_wb_rf_wa/we       in   5/1 WB-stage destination and write enable
//   i_haz_dmem_req          in   1   MEM stage issuing a dmem access
//   i_haz_dmem_ack          in   1   dmem access completes this cycle
//   o_haz_if/id/ex/mem_*    out  1   stage stall / flush controls
//   o_haz_id_rd1/rd2_sel    out  1   ID takes WB write data instead of RF read
//   o_haz_ex_fwd_a/b_sel    out  2   EX operand select: 00 reg, 01 MEM, 10 WB
//   o_haz_bus_err           out  1   sticky dmem timeout flag
//   o_haz_perf_stall_cnt    out  32  stall-cycle counter (zero when disabled)
//   o_haz_perf_flush_cnt    out  32  flush-event counter (zero when disabled)
// -----------------------------------------------------------------------------
interface rv_hazard_ctrl_if;
  logic [4:0]  i_haz_id_ra1;
  logic [4:0]  i_haz_id_ra2;
  logic [4:0]  i_haz_ex_ra1;
  logic [4:0]  i_haz_ex_ra2;
  logic [4:0]  i_haz_ex_rf_wa;
  logic        i_haz_ex_rf_we;
  logic        i_haz_ex_is_load;
  logic        i_haz_ex_redirect;
  logic [4:0]  i_haz_mem_rf_wa;
  logic        i_haz_mem_rf_we;
  logic [4:0]  i_haz_wb_rf_wa;
  logic        i_haz_wb_rf_we;
  logic        i_haz_dmem_req;
  logic        i_haz_dmem_ack;

  logic        o_haz_if_stall;
  logic        o_haz_if_flush;
  logic        o_haz_id_stall;
  logic        o_haz_id_flush;
  logic        o_haz_ex_stall;
  logic        o_haz_mem_stall;
  logic        o_haz_id_rd1_sel;
  logic        o_haz_id_rd2_sel;
  logic [1:0]  o_haz_ex_fwd_a_sel;
  logic [1:0]  o_haz_ex_fwd_b_sel;
  logic        o_haz_bus_err;
  logic [31:0] o_haz_perf_stall_cnt;
  logic [31:0] o_haz_perf_flush_cnt;

  modport master (
    output i_haz_id_ra1, i_haz_id_ra2, i_haz_ex_ra1, i_haz_ex_ra2,
           i_haz_ex_rf_wa, i_haz_ex_rf_we, i_haz_ex_is_load, i_haz_ex_redirect,
           i_haz_mem_rf_wa, i_haz_mem_rf_we, i_haz_wb_rf_wa, i_haz_wb_rf_we,
           i_haz_dmem_req, i_haz_dmem_ack,
    input  o_haz_if_stall, o_haz_if_flush, o_haz_id_stall, o_haz_id_flush,
           o_haz_ex_stall, o_haz_mem_stall, o_haz_id_rd1_sel, o_haz_id_rd2_sel,
           o_haz_ex_fwd_a_sel, o_haz_ex_fwd_b_sel, o_haz_bus_err,
           o_haz_perf_stall_cnt, o_haz_perf_flush_cnt
  );

  modport slave (
    input  i_haz_id_ra1, i_haz_id_ra2, i_haz_ex_ra1, i_haz_ex_ra2,
           i_haz_ex_rf_wa, i_haz_ex_rf_we, i_haz_ex_is_load, i_haz_ex_redirect,
           i_haz_mem_rf_wa, i_haz_mem_rf_we, i_haz_wb_rf_wa, i_haz_wb_rf_we,
           i_haz_dmem_req, i_haz_dmem_ack,
    output o_haz_if_stall, o_haz_if_flush, o_haz_id_stall, o_haz_id_flush,
           o_haz_ex_stall, o_haz_mem_stall, o_haz_id_rd1_sel, o_haz_id_rd2_sel,
           o_haz_ex_fwd_a_sel, o_haz_ex_fwd_b_sel, o_haz_bus_err,
           o_haz_perf_stall_cnt, o_haz_perf_flush_cnt
  );
endinterface

// File: rtl/rv_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// rv_hazard_ctrl
// Pipeline sequencer for the 5-stage RV32I core. Produces IF/ID/EX/MEM stall
// and flush controls, ID-stage WB bypass selects and EX-stage operand forward
// selects. A small FSM tracks outstanding data-memory accesses, freezes the
// whole pipe while one is pending and raises a sticky bus error if the access
// does not complete within MWAIT_MAX wait cycles.
//
// Parameters
//   MWAIT_MAX  max consecutive dmem wait cycles before bus error (>= 1)
//
// Ports
//   i_haz_clk   in  1  clock
//   i_haz_rstn  in  1  synchronous active-low reset
//   haz         rv_hazard_ctrl_if.slave  (all pipeline hazard signals)
//
// Optional build macro
//   RV_HAZ_PERF_CNT_EN : when defined, adds 32-bit stall-cycle and flush-event
//                        counters; when undefined the perf outputs read zero
//                        and no counter flops exist.
// -----------------------------------------------------------------------------
module rv_hazard_ctrl #(
  parameter int MWAIT_MAX = 16
) (
  input  logic            i_haz_clk,
  input  logic            i_haz_rstn,
  rv_hazard_ctrl_if.slave haz
);

  localparam int CW = $clog2(MWAIT_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MWAIT_MAX);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MWAIT = 2'd1,
    ST_ERR   = 2'd2
  } state_t;

  state_t        state_r;
  logic [CW-1:0] wait_cnt_r;
  logic          bus_err_r;

  logic          memstall_s;
  logic          load_use_s;
  logic          if_stall_s;
  logic          if_flush_s;
  logic          id_stall_s;
  logic          id_flush_s;
  logic          ex_stall_s;
  logic          mem_stall_s;
  logic [1:0]    fwd_a_sel_s;
  logic [1:0]    fwd_b_sel_s;

  // A producer matches a consumer only when it really writes a non-x0 register.
  function automatic logic reg_match(input logic [4:0] wa, input logic we,
                                     input logic [4:0] ra);
    reg_match = we & (wa != 5'd0) & (wa == ra);
  endfunction

  // EX operand select: the younger MEM result wins over the older WB result.
  function automatic logic [1:0] fwd_sel(input logic [4:0] ra,
                                         input logic [4:0] mem_wa, input logic mem_we,
                                         input logic [4:0] wb_wa,  input logic wb_we);
    if (reg_match(mem_wa, mem_we, ra)) begin
      fwd_sel = 2'b01;
    end else if (reg_match(wb_wa, wb_we, ra)) begin
      fwd_sel = 2'b10;
    end else begin
      fwd_sel = 2'b00;
    end
  endfunction

  // Pipe freeze: must be visible in the same cycle the dmem access is pending.
  always_comb begin
    memstall_s = 1'b0;
    case (state_r)
      ST_RUN:   memstall_s = haz.i_haz_dmem_req & ~haz.i_haz_dmem_ack;
      ST_MWAIT: memstall_s = ~haz.i_haz_dmem_ack;
      ST_ERR:   memstall_s = 1'b1;
      default:  memstall_s = 1'b1;
    endcase
  end

  // Load-use hazard between the load in EX and the instruction in ID.
  always_comb begin
    load_use_s = 1'b0;
    if (haz.i_haz_ex_is_load) begin
      load_use_s = reg_match(haz.i_haz_ex_rf_wa, haz.i_haz_ex_rf_we, haz.i_haz_id_ra1) |
                   reg_match(haz.i_haz_ex_rf_wa, haz.i_haz_ex_rf_we, haz.i_haz_id_ra2);
    end else begin
      load_use_s = 1'b0;
    end
  end

  // Stall/flush priority: memory freeze, then redirect, then load-use bubble.
  // A redirect seen during a freeze stays in EX and takes effect on release.
  always_comb begin
    if_stall_s  = 1'b0;
    if_flush_s  = 1'b0;
    id_stall_s  = 1'b0;
    id_flush_s  = 1'b0;
    ex_stall_s  = 1'b0;
    mem_stall_s = 1'b0;
    if (memstall_s) begin
      if_stall_s  = 1'b1;
      id_stall_s  = 1'b1;
      ex_stall_s  = 1'b1;
      mem_stall_s = 1'b1;
    end else if (haz.i_haz_ex_redirect) begin
      // Younger instructions are killed, so a load-use stall would be moot.
      if_flush_s = 1'b1;
      id_flush_s = 1'b1;
    end else if (load_use_s) begin
      // Hold IF/ID and insert one bubble into EX.
      if_stall_s = 1'b1;
      id_flush_s = 1'b1;
    end else begin
      if_stall_s = 1'b0;
    end
  end

  // Operand forward selects, independent of the memory FSM.
  always_comb begin
    fwd_a_sel_s = fwd_sel(haz.i_haz_ex_ra1, haz.i_haz_mem_rf_wa, haz.i_haz_mem_rf_we,
                          haz.i_haz_wb_rf_wa, haz.i_haz_wb_rf_we);
    fwd_b_sel_s = fwd_sel(haz.i_haz_ex_ra2, haz.i_haz_mem_rf_wa, haz.i_haz_mem_rf_we,
                          haz.i_haz_wb_rf_wa, haz.i_haz_wb_rf_we);
  end

  // Dmem wait FSM with timeout counter and sticky bus error.
  always_ff @(posedge i_haz_clk) begin
    if (!i_haz_rstn) begin
      state_r    <= ST_RUN;
      wait_cnt_r <= CNT_ZERO;
      bus_err_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (haz.i_haz_dmem_req && !haz.i_haz_dmem_ack) begin
            state_r    <= ST_MWAIT;
            wait_cnt_r <= CNT_ONE;
          end else begin
            state_r    <= ST_RUN;
            wait_cnt_r <= CNT_ZERO;
          end
        end
        ST_MWAIT: begin
          if (haz.i_haz_dmem_ack) begin
            state_r    <= ST_RUN;
            wait_cnt_r <= CNT_ZERO;
          end else if (wait_cnt_r == CNT_MAX) begin
            state_r   <= ST_ERR;
            bus_err_r <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + CNT_ONE;
          end
        end
        ST_ERR: begin
          // Terminal until reset.
          state_r   <= ST_ERR;
          bus_err_r <= 1'b1;
        end
        default: begin
          // An illegal encoding is treated as a bus fault so the pipe stays frozen.
          state_r   <= ST_ERR;
          bus_err_r <= 1'b1;
        end
      endcase
    end
  end

`ifdef RV_HAZ_PERF_CNT_EN
  logic [31:0] perf_stall_cnt_r;
  logic [31:0] perf_flush_cnt_r;

  // Stall-cycle and flush-event counters; both wrap naturally at 2^32.
  always_ff @(posedge i_haz_clk) begin
    if (!i_haz_rstn) begin
      perf_stall_cnt_r <= 32'd0;
      perf_flush_cnt_r <= 32'd0;
    end else begin
      if (if_stall_s) begin
        perf_stall_cnt_r <= perf_stall_cnt_r + 32'd1;
      end else begin
        perf_stall_cnt_r <= perf_stall_cnt_r;
      end
      if (if_flush_s || id_flush_s) begin
        perf_flush_cnt_r <= perf_flush_cnt_r + 32'd1;
      end else begin
        perf_flush_cnt_r <= perf_flush_cnt_r;
      end
    end
  end

  assign haz.o_haz_perf_stall_cnt = perf_stall_cnt_r;
  assign haz.o_haz_perf_flush_cnt = perf_flush_cnt_r;
`else
  assign haz.o_haz_perf_stall_cnt = 32'd0;
  assign haz.o_haz_perf_flush_cnt = 32'd0;
`endif

  assign haz.o_haz_if_stall     = if_stall_s;
  assign haz.o_haz_if_flush     = if_flush_s;
  assign haz.o_haz_id_stall     = id_stall_s;
  assign haz.o_haz_id_flush     = id_flush_s;
  assign haz.o_haz_ex_stall     = ex_stall_s;
  assign haz.o_haz_mem_stall    = mem_stall_s;
  assign haz.o_haz_ex_fwd_a_sel = fwd_a_sel_s;
  assign haz.o_haz_ex_fwd_b_sel = fwd_b_sel_s;
  assign haz.o_haz_id_rd1_sel   = reg_match(haz.i_haz_wb_rf_wa, haz.i_haz_wb_rf_we, haz.i_haz_id_ra1);
  assign haz.o_haz_id_rd2_sel   = reg_match(haz.i_haz_wb_rf_wa, haz.i_haz_wb_rf_we, haz.i_haz_id_ra2);
  assign haz.o_haz_bus_err      = bus_err_r;

endmodule
